mastermind_scorer: RTL and testbench

MASTERMIND_SCORER -- requirements
Module: mastermind_scorer

---
 rtl/mastermind_pkg.sv | 27 ++
 rtl/mastermind_scorer_if.sv | 26 ++
 rtl/mastermind_scorer_color_tally.sv | 47 ++++
 rtl/mastermind_scorer.sv | 123 ++++++++++++
 tb/tb_mastermind_scorer.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/mastermind_pkg.sv
// Shared sizing constants, FSM encoding and colour helper for the Mastermind scorer.
package mastermind_pkg;

  localparam int unsigned NUM_PEGS   = 4;
  localparam int unsigned COLOR_W    = 3;
  localparam int unsigned NUM_COLORS = 6;
  localparam int unsigned NUM_ROWS   = 6;
  localparam int unsigned FB_W       = 6;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned ROW_W      = 3;
  localparam int unsigned PEG_IDX_W  = $clog2(NUM_PEGS);
  localparam int unsigned CODE_W     = NUM_PEGS * COLOR_W;
  localparam int unsigned FLAT_W     = NUM_ROWS * FB_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXACT = 2'd1,
    TALLY = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Colours 0 and 7 are placeholders: they never match and are never counted.
  function automatic logic color_valid(input logic [COLOR_W-1:0] c);
    return (c != '0) && (c != '1);
  endfunction

endpackage

// File: rtl/mastermind_scorer_if.sv
// Request/result bundle between a game controller and the Mastermind scorer.
interface mastermind_scorer_if import mastermind_pkg::*; ();

  logic                  start;
  logic                  clear;
  logic [ROW_W-1:0]      row;
  logic [CODE_W-1:0]     guess;
  logic [CODE_W-1:0]     answer;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      exact_cnt;
  logic [CNT_W-1:0]      partial_cnt;
  logic                  win;
  logic [FLAT_W-1:0]     feedback_flat;

  modport master (
    output start, clear, row, guess, answer,
    input  busy, done, exact_cnt, partial_cnt, win, feedback_flat
  );

  modport slave (
    input  start, clear, row, guess, answer,
    output busy, done, exact_cnt, partial_cnt, win, feedback_flat
  );

endinterface

// File: rtl/mastermind_scorer_color_tally.sv
// Per-colour histograms of unmatched guess/answer pegs with a min() readout for one colour.
module mm_color_tally import mastermind_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               g_inc,
  input  logic [COLOR_W-1:0] g_color,
  input  logic               a_inc,
  input  logic [COLOR_W-1:0] a_color,
  input  logic [COLOR_W-1:0] sel_color,
  output logic [CNT_W-1:0]   min_cnt
);

  logic [CNT_W-1:0] g_hist [NUM_COLORS];
  logic [CNT_W-1:0] a_hist [NUM_COLORS];

  // Slot c holds colour c+1; counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_COLORS; c++) begin
        g_hist[c] <= '0;
        a_hist[c] <= '0;
      end
    end else if (clr) begin
      for (int unsigned c = 0; c < NUM_COLORS; c++) begin
        g_hist[c] <= '0;
        a_hist[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_COLORS; c++) begin
        if (g_inc && (g_color == COLOR_W'(c + 1)) && (g_hist[c] != '1))
          g_hist[c] <= g_hist[c] + CNT_W'(1);
        if (a_inc && (a_color == COLOR_W'(c + 1)) && (a_hist[c] != '1))
          a_hist[c] <= a_hist[c] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    min_cnt = '0;
    for (int unsigned c = 0; c < NUM_COLORS; c++) begin
      if (sel_color == COLOR_W'(c + 1))
        min_cnt = (g_hist[c] < a_hist[c]) ? g_hist[c] : a_hist[c];
    end
  end

endmodule

// File: rtl/mastermind_scorer.sv
// Multi-cycle Mastermind scorer: exact pass over pegs, then per-colour partial tally, with row history.
module mastermind_scorer import mastermind_pkg::*; (
  input  logic                Clk,
  input  logic                Reset_n,
  mastermind_scorer_if.slave  bus
);

  state_t                 state, state_n;
  logic [CODE_W-1:0]      g_q, a_q;
  logic [ROW_W-1:0]       row_q;
  logic [PEG_IDX_W-1:0]   peg_idx;
  logic [COLOR_W-1:0]     color_idx;
  logic [CNT_W-1:0]       exact_acc, partial_acc, partial_next;
  logic [CNT_W-1:0]       exact_q, partial_q;
  logic                   win_q;
  logic [FLAT_W-1:0]      fb_q;

  logic [COLOR_W-1:0]     g_peg, a_peg;
  logic                   peg_match, in_exact, take_start, hist_clr;
  logic                   g_inc, a_inc, last_peg, last_color;
  logic [CNT_W-1:0]       min_cnt;

  assign g_peg      = g_q[peg_idx*COLOR_W +: COLOR_W];
  assign a_peg      = a_q[peg_idx*COLOR_W +: COLOR_W];
  assign peg_match  = color_valid(g_peg) && (g_peg == a_peg);
  assign in_exact   = (state == EXACT) && !bus.clear;
  assign g_inc      = in_exact && !peg_match && color_valid(g_peg);
  assign a_inc      = in_exact && !peg_match && color_valid(a_peg);
  assign take_start = (state == IDLE) && bus.start && !bus.clear;
  assign hist_clr   = bus.clear || take_start;
  assign last_peg   = (peg_idx == PEG_IDX_W'(NUM_PEGS - 1));
  assign last_color = (color_idx == COLOR_W'(NUM_COLORS));
  assign partial_next = partial_acc + min_cnt;

  mm_color_tally u_tally (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .clr       (hist_clr),
    .g_inc     (g_inc),
    .g_color   (g_peg),
    .a_inc     (a_inc),
    .a_color   (a_peg),
    .sel_color (color_idx),
    .min_cnt   (min_cnt)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (take_start) state_n = EXACT;
      EXACT:   if (last_peg)   state_n = TALLY;
      TALLY:   if (last_color) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.clear) state_n = IDLE;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      g_q         <= '0;
      a_q         <= '0;
      row_q       <= '0;
      peg_idx     <= '0;
      color_idx   <= '0;
      exact_acc   <= '0;
      partial_acc <= '0;
      exact_q     <= '0;
      partial_q   <= '0;
      win_q       <= 1'b0;
      fb_q        <= '0;
    end else if (bus.clear) begin
      exact_acc   <= '0;
      partial_acc <= '0;
      exact_q     <= '0;
      partial_q   <= '0;
      win_q       <= 1'b0;
      fb_q        <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          g_q         <= bus.guess;
          a_q         <= bus.answer;
          row_q       <= bus.row;
          exact_acc   <= '0;
          partial_acc <= '0;
          peg_idx     <= '0;
          color_idx   <= COLOR_W'(1);
        end
        EXACT: begin
          if (peg_match) exact_acc <= exact_acc + CNT_W'(1);
          peg_idx <= peg_idx + PEG_IDX_W'(1);
        end
        TALLY: begin
          partial_acc <= partial_next;
          color_idx   <= color_idx + COLOR_W'(1);
          // The last colour's min is folded in here, so results use partial_next.
          if (last_color) begin
            exact_q   <= exact_acc;
            partial_q <= partial_next;
            win_q     <= (exact_acc == CNT_W'(NUM_PEGS));
            if (row_q < ROW_W'(NUM_ROWS))
              fb_q[row_q*FB_W +: FB_W] <= {exact_acc, partial_next};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy          = (state == EXACT) || (state == TALLY);
  assign bus.done          = (state == DONE);
  assign bus.exact_cnt     = exact_q;
  assign bus.partial_cnt   = partial_q;
  assign bus.win           = win_q;
  assign bus.feedback_flat = fb_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Directed-vector bench for mastermind_scorer with hand-computed scores and history.
module tb_mastermind_scorer;
  import mastermind_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  mastermind_scorer_if bus ();

  mastermind_scorer dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  localparam int NONE = 999;

  int   done_first;
  int   done_n;
  logic busy_h [0:35];

  // Cycle 0 is the cycle in which start is driven; busy/done are sampled per cycle on the falling edge.
  task automatic run(input logic [11:0] g, input logic [11:0] a, input logic [2:0] r,
                     input int ss, input int clr_at, input int rst_at);
    done_first = -1;
    done_n     = 0;
    @(negedge Clk);
    for (int k = 0; k < 36; k++) begin
      if (k > 0) @(negedge Clk);
      busy_h[k] = bus.busy;
      if (bus.done) begin
        done_n++;
        if (done_first < 0) done_first = k;
      end
      bus.start = (k == 0) || (k == ss);
      bus.clear = (k == clr_at);
      if (k == 0) begin
        bus.guess  = g;
        bus.answer = a;
        bus.row    = r;
      end else if (k == ss) begin
        bus.guess  = 12'h000;
        bus.answer = 12'hFFF;
        bus.row    = 3'd4;
      end
      if (k == rst_at) begin
        Reset_n = 1'b0;
        #1;
        chk("rst_busy",    36'(bus.busy),        36'd0);
        chk("rst_done",    36'(bus.done),        36'd0);
        chk("rst_exact",   36'(bus.exact_cnt),   36'd0);
        chk("rst_partial", 36'(bus.partial_cnt), 36'd0);
        chk("rst_win",     36'(bus.win),         36'd0);
        chk("rst_fb",      bus.feedback_flat,    36'd0);
      end
      if (k == rst_at + 2) Reset_n = 1'b1;
    end
    bus.start = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [2:0] ex, input logic [2:0] pa,
                            input logic w, input logic [35:0] fb);
    chk({tag, "_done_at"}, 36'(done_first), 36'd11);
    chk({tag, "_done_n"},  36'(done_n),     36'd1);
    chk({tag, "_exact"},   36'(bus.exact_cnt),   36'(ex));
    chk({tag, "_partial"}, 36'(bus.partial_cnt), 36'(pa));
    chk({tag, "_win"},     36'(bus.win),         36'(w));
    chk({tag, "_fb"},      bus.feedback_flat,    fb);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.clear  = 1'b0;
    bus.row    = '0;
    bus.guess  = '0;
    bus.answer = '0;
    Reset_n    = 1'b0;
    repeat (2) @(negedge Clk);
    chk("init_busy",    36'(bus.busy),        36'd0);
    chk("init_done",    36'(bus.done),        36'd0);
    chk("init_exact",   36'(bus.exact_cnt),   36'd0);
    chk("init_win",     36'(bus.win),         36'd0);
    chk("init_fb",      bus.feedback_flat,    36'd0);
    Reset_n = 1'b1;

    run(12'h249, 12'h249, 3'd0, NONE, NONE, NONE);
    chk_result("all_ones", 3'd4, 3'd0, 1'b1, 36'h0_0000_0020);
    chk("busy_c1",  36'(busy_h[1]),  36'd1);
    chk("busy_c10", 36'(busy_h[10]), 36'd1);
    chk("busy_c11", 36'(busy_h[11]), 36'd0);

    run(12'h29C, 12'h8D1, 3'd1, NONE, NONE, NONE);
    chk_result("reversed", 3'd0, 3'd4, 1'b0, 36'h0_0000_0120);

    run(12'h252, 12'h8D1, 3'd2, NONE, NONE, NONE);
    chk_result("dup_guess", 3'd1, 3'd1, 1'b0, 36'h0_0000_9120);

    run(12'h280, 12'h249, 3'd3, NONE, NONE, NONE);
    chk_result("blank_pegs", 3'd1, 3'd0, 1'b0, 36'h0_0020_9120);

    run(12'hFFF, 12'hFFF, 3'd4, NONE, NONE, NONE);
    chk_result("color7", 3'd0, 3'd0, 1'b0, 36'h0_0020_9120);

    run(12'h8D1, 12'h8D1, 3'd5, 3, NONE, NONE);
    chk_result("restart_ign", 3'd4, 3'd0, 1'b1, 36'h8_0020_9120);

    run(12'h29C, 12'h8D1, 3'd6, NONE, NONE, NONE);
    chk_result("row6", 3'd0, 3'd4, 1'b0, 36'h8_0020_9120);

    run(12'h249, 12'h249, 3'd0, NONE, 5, NONE);
    chk("clr_busy_c6", 36'(busy_h[6]),         36'd0);
    chk("clr_done_n",  36'(done_n),            36'd0);
    chk("clr_exact",   36'(bus.exact_cnt),     36'd0);
    chk("clr_partial", 36'(bus.partial_cnt),   36'd0);
    chk("clr_win",     36'(bus.win),           36'd0);
    chk("clr_fb",      bus.feedback_flat,      36'd0);

    @(negedge Clk);
    bus.start  = 1'b1;
    bus.clear  = 1'b1;
    bus.guess  = 12'h249;
    bus.answer = 12'h249;
    bus.row    = 3'd0;
    @(negedge Clk);
    bus.start = 1'b0;
    bus.clear = 1'b0;
    chk("clrstart_busy", 36'(bus.busy), 36'd0);
    @(negedge Clk);
    chk("clrstart_busy2", 36'(bus.busy), 36'd0);

    run(12'h249, 12'h249, 3'd0, NONE, NONE, NONE);
    chk_result("pre_rst", 3'd4, 3'd0, 1'b1, 36'h0_0000_0020);

    run(12'h8D1, 12'h8D1, 3'd1, NONE, NONE, 7);
    chk("rst_done_n", 36'(done_n),          36'd0);
    chk("rst_fb_end", bus.feedback_flat,    36'd0);
    chk("rst_busy_end", 36'(bus.busy),      36'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
